// File: rtl/ccm_in_buffer.sv
// Input staging FIFO ahead of the CCM counter stage: absorbs bursts under
// backpressure and zero-pads every message to a whole number of AES blocks.
module ccm_in_buffer #(
   parameter int WIDTH       = 8,
   parameter int DEPTH       = 32,
   parameter int BLOCK_BYTES = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] input_data,
   input  logic             input_en,
   input  logic             input_last,
   output logic             in_ready,
   output logic             in_overflow,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_en,
   output logic             out_last
);

   // state     | meaning
   // ST_STREAM | popping FIFO entries and forwarding them
   // ST_PAD    | emitting zero bytes until the current block is complete
   typedef enum logic {ST_STREAM, ST_PAD} state_t;

   localparam int AW = $clog2(DEPTH);
   localparam int PW = $clog2(BLOCK_BYTES);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL     = CW'(DEPTH);
   localparam logic [PW-1:0] LAST_POS = PW'(BLOCK_BYTES - 1);

   logic [WIDTH:0]   r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic [PW-1:0]    r_pos;
   state_t           r_state;
   logic [WIDTH-1:0] r_out_data;
   logic             r_out_en;
   logic             r_out_last;
   logic             r_overflow;

   logic             w_in_ready;
   logic             w_push;
   logic             w_emit;
   logic             w_pop;
   logic [WIDTH:0]   w_head;
   logic [PW-1:0]    w_pos_next;
   logic             w_block_end;

   assign w_in_ready  = (r_count != FULL);
   assign w_push      = input_en && w_in_ready;
   assign w_emit      = out_ready && ((r_state == ST_PAD) || (r_count != '0));
   assign w_pop       = w_emit && (r_state == ST_STREAM);
   assign w_head      = r_mem[r_rd_ptr];
   assign w_block_end = (r_pos == LAST_POS);
   assign w_pos_next  = w_block_end ? '0 : r_pos + PW'(1);

   assign in_ready    = w_in_ready;
   assign in_overflow = r_overflow;
   assign out_data    = r_out_data;
   assign out_en      = r_out_en;
   assign out_last    = r_out_last;

   // Storage carries no reset; validity is tracked entirely by r_count.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {input_last, input_data};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         if (input_en && !w_in_ready) begin
            r_overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_STREAM;
         r_pos      <= '0;
         r_out_data <= '0;
         r_out_en   <= 1'b0;
         r_out_last <= 1'b0;
      end else begin
         r_out_en   <= w_emit;
         r_out_last <= 1'b0;
         case (r_state)
            ST_STREAM: begin
               if (w_emit) begin
                  r_out_data <= w_head[WIDTH-1:0];
                  r_pos      <= w_pos_next;
                  if (w_head[WIDTH]) begin
                     if (w_block_end) begin
                        r_out_last <= 1'b1;
                     end else begin
                        r_state <= ST_PAD;
                     end
                  end
               end
            end
            ST_PAD: begin
               if (w_emit) begin
                  r_out_data <= '0;
                  r_pos      <= w_pos_next;
                  if (w_block_end) begin
                     r_out_last <= 1'b1;
                     r_state    <= ST_STREAM;
                  end
               end
            end
            default: r_state <= ST_STREAM;
         endcase
      end
   end

endmodule

// File: tb/tb_ccm_in_buffer.sv
// Self-checking bench for ccm_in_buffer: directed scenarios plus random traffic
// compared cycle by cycle against a queue-based model of the padded stream.
module tb_ccm_in_buffer;

   localparam int DEPTH = 32;
   localparam int BLK   = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] input_data = '0;
   logic       input_en = 1'b0;
   logic       input_last = 1'b0;
   logic       in_ready;
   logic       in_overflow;
   logic       out_ready = 1'b0;
   logic [7:0] out_data;
   logic       out_en;
   logic       out_last;

   ccm_in_buffer #(.WIDTH(8), .DEPTH(DEPTH), .BLOCK_BYTES(BLK)) dut (
      .clk(clk), .reset(reset),
      .input_data(input_data), .input_en(input_en), .input_last(input_last),
      .in_ready(in_ready), .in_overflow(in_overflow),
      .out_ready(out_ready),
      .out_data(out_data), .out_en(out_en), .out_last(out_last)
   );

   always #5 clk = ~clk;

   int pass_cnt = 0;
   int total    = 0;

   // Model: bytes waiting in the buffer, pad bytes still owed, bytes emitted
   // in the current block, and the last values the outputs should show.
   logic [8:0] fq[$];
   int         pad_rem = 0;
   int         blk_n   = 0;
   logic       m_ovf   = 1'b0;
   logic [7:0] m_data  = '0;
   logic       m_en    = 1'b0;
   logic       m_last  = 1'b0;
   int         n_emit  = 0;
   int         n_last  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step(input logic en, input logic lst, input logic [7:0] d, input logic rdy);
      logic       acc;
      logic       emit;
      logic [8:0] ent;
      input_en   = en;
      input_last = lst;
      input_data = d;
      out_ready  = rdy;
      acc  = en && (fq.size() != DEPTH);
      emit = rdy && (pad_rem != 0 || fq.size() != 0);
      if (en && !acc) m_ovf = 1'b1;
      m_last = 1'b0;
      if (emit) begin
         n_emit++;
         if (pad_rem != 0) begin
            m_data = 8'h00;
            pad_rem--;
            if (pad_rem == 0) begin
               m_last = 1'b1;
               blk_n  = 0;
            end
         end else begin
            ent    = fq.pop_front();
            m_data = ent[7:0];
            blk_n  = (blk_n + 1) % BLK;
            if (ent[8]) begin
               if (blk_n == 0) m_last = 1'b1;
               else pad_rem = BLK - blk_n;
            end
         end
         if (m_last) n_last++;
      end
      m_en = emit;
      if (acc) fq.push_back({lst, d});
      @(posedge clk);
      #1;
      chk("out_en", 32'(out_en), 32'(m_en));
      chk("out_last", 32'(out_last), 32'(m_last));
      chk("out_data", 32'(out_data), 32'(m_data));
      chk("in_ready", 32'(in_ready), 32'(fq.size() != DEPTH));
      chk("in_overflow", 32'(in_overflow), 32'(m_ovf));
   endtask

   task automatic do_reset();
      reset = 1'b0;
      input_en = 1'b0;
      input_last = 1'b0;
      out_ready = 1'b0;
      #1;
      chk("rst_out_en", 32'(out_en), 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_in_overflow", 32'(in_overflow), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      fq.delete();
      pad_rem = 0;
      blk_n   = 0;
      m_ovf   = 1'b0;
      m_data  = '0;
      m_en    = 1'b0;
      m_last  = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic drain(input int cycles);
      for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
   endtask

   initial begin
      int e0;
      int l0;
      int remaining;
      logic lst;
      #2;
      do_reset();

      // 16-byte message 0x00..0x0F, no padding expected
      e0 = n_emit; l0 = n_last;
      for (int i = 0; i < 16; i++) step(1'b1, i == 15, 8'(i), 1'b1);
      drain(4);
      chk("msg16_emitted", 32'(n_emit - e0), 32'd16);
      chk("msg16_lasts", 32'(n_last - l0), 32'd1);

      // 34-byte message padded to 48
      e0 = n_emit; l0 = n_last;
      for (int i = 1; i <= 34; i++) step(1'b1, i == 34, 8'(i), 1'b1);
      drain(20);
      chk("msg34_emitted", 32'(n_emit - e0), 32'd48);
      chk("msg34_lasts", 32'(n_last - l0), 32'd1);

      // 1-byte message immediately followed by 16-byte message
      e0 = n_emit;
      step(1'b1, 1'b1, 8'hAB, 1'b1);
      for (int i = 0; i < 16; i++) step(1'b1, i == 15, 8'(8'h10 + i), 1'b1);
      drain(20);
      chk("msg1_16_emitted", 32'(n_emit - e0), 32'd32);

      // 5-byte message with out_ready toggling during padding
      e0 = n_emit; l0 = n_last;
      for (int i = 0; i < 5; i++) step(1'b1, i == 4, 8'(8'h50 + i), 1'b1);
      for (int i = 0; i < 24; i++) step(1'b0, 1'b0, 8'h00, 1'(i % 2));
      chk("msg5_emitted", 32'(n_emit - e0), 32'd16);
      chk("msg5_lasts", 32'(n_last - l0), 32'd1);

      // overflow: 40 pushes with out_ready low, only 32 survive
      e0 = n_emit;
      for (int i = 0; i < 40; i++) step(1'b1, (i == 31) || (i == 39), 8'(8'h80 + i), 1'b0);
      chk("ovf_sticky", 32'(in_overflow), 32'd1);
      drain(40);
      chk("ovf_emitted", 32'(n_emit - e0), 32'd32);

      // reset after 7 bytes of a 20-byte message have been emitted
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'hC0 + i), 1'b1);
      do_reset();
      e0 = n_emit; l0 = n_last;
      for (int i = 0; i < 16; i++) step(1'b1, i == 15, 8'(8'hE0 + i), 1'b1);
      drain(4);
      chk("post_rst_emitted", 32'(n_emit - e0), 32'd16);
      chk("post_rst_lasts", 32'(n_last - l0), 32'd1);

      // random traffic
      remaining = 0;
      for (int i = 0; i < 900; i++) begin
         logic en;
         logic rdy;
         logic [7:0] d;
         if (remaining == 0) remaining = int'($urandom_range(1, 40));
         en  = ($urandom % 4) != 0;
         rdy = ($urandom % 3) != 0;
         d   = 8'($urandom);
         lst = (remaining == 1);
         if (en && fq.size() != DEPTH) remaining--;
         step(en, lst, d, rdy);
      end
      drain(80);
      chk("rand_drained_q", 32'(fq.size()), 32'd0);
      chk("rand_drained_pad", 32'(pad_rem), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
